mem_port_arbiter: RTL and testbench

Shares the processor's single-ported memory between instruction fetch and the data stage (load/store). Grants one requester at a time, drives the memory port for a fixed-latency access, and returns data with a one-cycle valid pulse. Raises stall outputs so control can hold the pipeline while an access is pending. Sits between the datapath's fetch/memory stages and the memory model.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_lat_cnt.sv | 29 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Latency-counter width: must hold MEM_LAT itself, i.e. $clog2(MEM_LAT+1).
    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    localparam int MEM_LAT_DEFAULT = 1;
    localparam int LAT_CW_DEFAULT  = $clog2(MEM_LAT_DEFAULT + 1);

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter timing the WAIT phase; done marks the final wait cycle.
module arb_lat_cnt #(
    parameter int CW       = 1,
    parameter int LOAD_VAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CW'(LOAD_VAL);
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    // Flag the cycle in which the count is about to reach zero, so the
    // WAIT phase lasts exactly LOAD_VAL cycles.
    assign done = (cnt_reg == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store traffic.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 12,
    parameter int W          = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [W-1:0]  if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [W-1:0]  d_wdata,
    output logic [W-1:0]  d_rdata,
    output logic          d_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    input  logic [W-1:0]  mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int CW = lat_cnt_w(MEM_LAT);

    arb_state_t    state_reg, state_next;
    owner_t        owner_reg, owner_next;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [W-1:0]  mem_wdata_reg;

    logic any_req;
    logic grant_d;
    logic starve_force;
    logic cnt_load;
    logic cnt_dec;
    logic lat_done;
    logic access_done;

    assign any_req = if_req | d_req;
    assign grant_d = d_req & ~(if_req & starve_force);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_cnt_reg;

    assign starve_force = (starve_cnt_reg == SCW'(STARVE_MAX));

    // Counts data grants won while fetch is waiting; saturates at STARVE_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
        end else if (!if_req) begin
            starve_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (!grant_d) begin
                starve_cnt_reg <= '0;
            end else if (!starve_force) begin
                starve_cnt_reg <= starve_cnt_reg + SCW'(1);
            end
        end
    end
`else
    // Without the guard fetch is never forced ahead of data.
    assign starve_force = (STARVE_MAX < 0);
`endif

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                    owner_next = grant_d ? OWN_D : OWN_IF;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_load   = 1'b1;
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (lat_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_IF;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            if ((state_reg == IDLE) && any_req) begin
                mem_addr_reg  <= grant_d ? d_addr : if_addr;
                mem_we_reg    <= grant_d & d_we;
                mem_wdata_reg <= grant_d ? d_wdata : '0;
            end
        end
    end

    arb_lat_cnt #(
        .CW       (CW),
        .LOAD_VAL (MEM_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .done (lat_done)
    );

    assign access_done = (state_reg == WAIT) & lat_done;

    assign mem_en    = (state_reg == ISSUE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    assign if_valid = access_done & (owner_reg == OWN_IF);
    assign d_valid  = access_done & (owner_reg == OWN_D);
    assign if_rdata = if_valid ? mem_rdata : '0;
    // Store completions return zero rather than whatever the memory drives.
    assign d_rdata  = (d_valid & ~mem_we_reg) ? mem_rdata : '0;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance with a memory
// model, plus a MEM_LAT=3 instance for the reset-during-access case.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (MEM_LAT = 1)
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [W-1:0]  d_wdata;
    logic [W-1:0]  if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem;
    logic [AW-1:0] mem_addr;

    // Second instance (MEM_LAT = 3)
    logic          rst3;
    logic          if_req3, d_req3, d_we3;
    logic [AW-1:0] if_addr3, d_addr3;
    logic [W-1:0]  d_wdata3;
    logic [W-1:0]  if_rdata3, d_rdata3, mem_wdata3;
    logic          if_valid3, d_valid3, mem_en3, mem_we3, stall_if3, stall_mem3;
    logic [AW-1:0] mem_addr3;

    mem_port_arbiter #(
        .AW(AW), .W(W), .MEM_LAT(1), .STARVE_MAX(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(
        .AW(AW), .W(W), .MEM_LAT(3), .STARVE_MAX(4)
    ) u_dut3 (
        .clk(clk), .rst(rst3),
        .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_valid(if_valid3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_rdata(d_rdata3), .d_valid(d_valid3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(16'hA5A5), .stall_if(stall_if3), .stall_mem(stall_mem3)
    );

    // Memory model for the main instance: one-cycle registered read, preload port.
    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [W-1:0]  rdata_q;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [W-1:0]  pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            rdata_q <= mem[mem_addr];
        end
    end
    assign mem_rdata = rdata_q;

    int test_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] v);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = v;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int fetch_pos;
        int cyc;
        int pulses;

        rst = 1'b0; rst3 = 1'b0;
        if_req = 1'b1; if_addr = 12'h010; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;
        if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0;
        d_addr3 = '0; d_wdata3 = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset state (fetch request already high: stall_if must follow it)
        preload(12'h010, 16'hBEEF);
        preload(12'h030, 16'h3333);
        preload(12'h040, 16'h4444);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_stall_if", stall_if, 1);
        rst = 1'b1; rst3 = 1'b1;

        // Fetch only: request sampled at the next edge (cycle 0)
        tick();
        check("fetch_mem_en", mem_en, 1);
        check("fetch_mem_addr", mem_addr, 12'h010);
        check("fetch_mem_we", mem_we, 0);
        check("fetch_stall_pending", stall_if, 1);
        tick();
        check("fetch_if_valid", if_valid, 1);
        check("fetch_if_rdata", if_rdata, 16'hBEEF);
        check("fetch_stall_drop", stall_if, 0);
        check("fetch_d_valid", d_valid, 0);
        if_req = 1'b0;
        tick();
        check("fetch_valid_one_cycle", if_valid, 0);
        check("fetch_idle_mem_en", mem_en, 0);

        // Store 0x1234 to 0x020
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h020; d_wdata = 16'h1234;
        tick();
        check("store_mem_en", mem_en, 1);
        check("store_mem_we", mem_we, 1);
        check("store_mem_addr", mem_addr, 12'h020);
        check("store_mem_wdata", mem_wdata, 16'h1234);
        tick();
        check("store_d_valid", d_valid, 1);
        check("store_d_rdata", d_rdata, 0);
        check("store_stall_mem", stall_mem, 0);
        check("store_if_valid", if_valid, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Fetch back the stored word
        if_req = 1'b1; if_addr = 12'h020;
        tick();
        check("refetch_mem_we", mem_we, 0);
        tick();
        check("refetch_if_valid", if_valid, 1);
        check("refetch_if_rdata", if_rdata, 16'h1234);
        if_req = 1'b0;
        tick();

        // Load from 0x010
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h010;
        tick();
        check("load_mem_addr", mem_addr, 12'h010);
        tick();
        check("load_d_valid", d_valid, 1);
        check("load_d_rdata", d_rdata, 16'hBEEF);
        check("load_if_rdata", if_rdata, 0);
        d_req = 1'b0;
        tick();

        // Simultaneous: data first, fetch granted in the following IDLE
        if_req = 1'b1; if_addr = 12'h030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h040;
        tick();
        check("tie_c1_mem_en", mem_en, 1);
        check("tie_c1_mem_addr", mem_addr, 12'h040);
        tick();
        check("tie_c2_d_valid", d_valid, 1);
        check("tie_c2_d_rdata", d_rdata, 16'h4444);
        check("tie_c2_if_valid", if_valid, 0);
        check("tie_c2_stall_if", stall_if, 1);
        d_req = 1'b0;
        tick();
        check("tie_c3_mem_en", mem_en, 0);
        tick();
        check("tie_c4_mem_en", mem_en, 1);
        check("tie_c4_mem_addr", mem_addr, 12'h030);
        tick();
        check("tie_c5_if_valid", if_valid, 1);
        check("tie_c5_if_rdata", if_rdata, 16'h3333);
        if_req = 1'b0;
        tick();

        // Starvation: both requests held continuously, observe first 5 grants
        if_req = 1'b1; if_addr = 12'h050;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h060;
        grants = 0; fetch_pos = 99; cyc = 0;
        while (grants < 5 && cyc < 60) begin
            tick();
            cyc++;
            if (mem_en) begin
                if (mem_addr == 12'h050 && fetch_pos == 99) fetch_pos = grants;
                grants++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("starve_grants", grants, 5);
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_fetch_pos", fetch_pos, 4);
`else
        check("starve_fetch_pos", fetch_pos, 99);
`endif
        repeat (4) tick();
        check("starve_idle_mem_en", mem_en, 0);

        // Reset during WAIT on the MEM_LAT=3 instance
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 12'h0AA;
        tick();
        check("r3_c1_mem_en", mem_en3, 1);
        check("r3_c1_mem_addr", mem_addr3, 12'h0AA);
        tick();
        rst3 = 1'b0;
        #1;
        check("r3_rst_mem_en", mem_en3, 0);
        check("r3_rst_mem_addr", mem_addr3, 0);
        check("r3_rst_mem_we", mem_we3, 0);
        check("r3_rst_mem_wdata", mem_wdata3, 0);
        check("r3_rst_d_valid", d_valid3, 0);
        check("r3_rst_d_rdata", d_rdata3, 0);
        check("r3_rst_if_valid", if_valid3, 0);
        check("r3_rst_stall_mem", stall_mem3, 1);
        pulses = 0;
        repeat (4) begin
            tick();
            if (d_valid3 || mem_en3) pulses++;
        end
        check("r3_no_activity_in_rst", pulses, 0);
        rst3 = 1'b1;
        tick();
        check("r3_rel_mem_en", mem_en3, 1);
        tick();
        check("r3_rel_c2_d_valid", d_valid3, 0);
        tick();
        check("r3_rel_c3_d_valid", d_valid3, 0);
        tick();
        check("r3_rel_c4_d_valid", d_valid3, 1);
        check("r3_rel_c4_d_rdata", d_rdata3, 16'hA5A5);
        d_req3 = 1'b0;
        tick();
        check("r3_rel_c5_d_valid", d_valid3, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
